// File: rtl/sram_controller.sv
// Single-port SRAM access sequencer for the MEM stage: stretches each load/store
// over WAIT_CYCLES clocks, freezing the pipeline through ready until it completes.
module sram_controller #(
   parameter int unsigned WAIT_CYCLES = 5,
   parameter int unsigned BASE_ADDR   = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [16:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   inout  wire  [63:0] SRAM_DQ,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   state_t      state;
   logic [3:0]  cnt;
   logic        op_wr;
   logic [16:0] word_addr;
   logic [31:0] wdata_q;

   // Handshake: the requester holds wr_en/rd_en until it sees ready=1; a request
   // still present in the cycle after DONE starts a fresh access.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         op_wr     <= 1'b0;
         word_addr <= 17'd0;
         wdata_q   <= 32'd0;
         read_data <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_en || rd_en) begin
                  op_wr     <= wr_en;  // write wins when both are asserted
                  word_addr <= 17'((address - 32'(BASE_ADDR)) >> 2);
                  wdata_q   <= write_data;
                  cnt       <= 4'd0;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               cnt <= cnt + 4'd1;
               if (cnt == LAST_CNT) begin
                  state <= DONE;
                  if (!op_wr)
                     read_data <= word_addr[0] ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign ready     = (state == DONE) || ((state == IDLE) && !(wr_en || rd_en));
   assign SRAM_ADDR = (state == ACCESS) ? word_addr : 17'd0;
   assign SRAM_WE_N = !((state == ACCESS) && op_wr);
   assign SRAM_DQ   = SRAM_WE_N ? {64{1'bz}} : {32'd0, wdata_q};
   assign dbg_state = state;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized bench for sram_controller with an SRAM bus model and a
// transaction-level memory reference.
module tb_sram_controller;

   localparam int unsigned WAIT_CYCLES = 5;
   localparam int unsigned BASE_ADDR   = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en, rd_en;
   logic [31:0] address, write_data;
   logic [31:0] read_data;
   logic        ready;
   logic [16:0] sram_addr;
   logic        sram_we_n;
   wire  [63:0] sram_dq;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   // SRAM bus model
   logic [31:0] sram_mem [0:131071];
   logic [63:0] sram_rd_bus;

   // reference: word address -> last written value
   bit [31:0]   ref_mem [int];
   logic [31:0] exp_rd;

   sram_controller #(
      .WAIT_CYCLES(WAIT_CYCLES),
      .BASE_ADDR  (BASE_ADDR)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .address   (address),
      .write_data(write_data),
      .read_data (read_data),
      .ready     (ready),
      .SRAM_ADDR (sram_addr),
      .SRAM_WE_N (sram_we_n),
      .SRAM_DQ   (sram_dq),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   assign sram_rd_bus = {sram_mem[{sram_addr[16:1], 1'b1}], sram_mem[{sram_addr[16:1], 1'b0}]};
   assign sram_dq     = sram_we_n ? sram_rd_bus : {64{1'bz}};

   always @(posedge clk) begin
      if (!sram_we_n)
         sram_mem[sram_addr] <= sram_dq[31:0];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [16:0] word_of(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - 32'(BASE_ADDR);
      return off[18:2];
   endfunction

   // One complete access; returns at the negedge of the DONE cycle.
   task automatic do_access(input bit wr, input bit rd, input logic [31:0] addr,
                            input logic [31:0] data, input bit hold);
      logic [16:0] wa;
      @(negedge clk);
      wr_en      = wr;
      rd_en      = rd;
      address    = addr;
      write_data = data;
      wa = word_of(addr);
      #1 check("idle_ready_req", ready, 0);
      @(posedge clk);
      for (int i = 0; i < int'(WAIT_CYCLES); i++) begin
         @(negedge clk);
         check("acc_ready", ready, 0);
         check("acc_addr", sram_addr, wa);
         check("acc_we_n", sram_we_n, !wr);
         if (wr) check("acc_dq", sram_dq, {32'd0, data});
         address    = $urandom;
         write_data = $urandom;
      end
      if (wr) ref_mem[int'(wa)] = data;
      else    exp_rd = ref_mem[int'(wa)];
      @(negedge clk);
      check("done_ready", ready, 1);
      check("done_addr", sram_addr, 0);
      check("done_we_n", sram_we_n, 1);
      check("done_rdata", read_data, exp_rd);
      if (wr) check("sram_word", sram_mem[wa], data);
      if (!hold) begin
         wr_en = 1'b0;
         rd_en = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] a, d;
      logic [16:0] wa;
      bit wr, rd;
      for (int i = 0; i < 131072; i++) sram_mem[i] = 32'd0;
      exp_rd     = 32'd0;
      reset      = 1'b1;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      address    = 32'd0;
      write_data = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_addr", sram_addr, 0);
      check("rst_we_n", sram_we_n, 1);
      check("rst_rdata", read_data, 0);
      reset = 1'b0;

      // directed cases
      do_access(1, 0, 32'd1024, 32'hDEADBEEF, 0);
      do_access(1, 0, 32'd1028, 32'h12345678, 0);
      do_access(0, 1, 32'd1028, 32'h0, 0);
      check("rd_upper", read_data, 32'h12345678);
      do_access(0, 1, 32'd1024, 32'h0, 0);
      check("rd_lower", read_data, 32'hDEADBEEF);
      do_access(1, 1, 32'd1032, 32'hA5A5A5A5, 0);
      check("wr_prio_rdata", read_data, 32'hDEADBEEF);
      do_access(0, 1, 32'd1020, 32'h0, 0);
      do_access(0, 1, 32'd1028, 32'h0, 1);
      do_access(0, 1, 32'd1032, 32'h0, 0);
      check("b2b_rdata", read_data, 32'hA5A5A5A5);

      // randomized traffic over a small window so reads hit prior writes
      for (int n = 0; n < 60; n++) begin
         a  = 32'(BASE_ADDR) + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
         d  = $urandom;
         wr = 1'($urandom_range(0, 1));
         rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         do_access(wr, rd, a, d, 0);
      end

      // reset on the third ACCESS cycle of a write
      @(negedge clk);
      a = 32'(BASE_ADDR) + 32'd160;
      d = $urandom;
      wa = word_of(a);
      wr_en      = 1'b1;
      address    = a;
      write_data = d;
      @(posedge clk);
      repeat (3) @(negedge clk);
      check("abort_we_n_pre", sram_we_n, 0);
      reset = 1'b1;
      wr_en = 1'b0;
      ref_mem[int'(wa)] = d;
      exp_rd = 32'd0;
      @(negedge clk);
      check("abort_ready", ready, 1);
      check("abort_we_n", sram_we_n, 1);
      check("abort_addr", sram_addr, 0);
      check("abort_rdata", read_data, 0);
      reset = 1'b0;

      do_access(0, 1, a, 32'h0, 0);
      do_access(0, 1, 32'd1032, 32'h0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 5: number of cycles the SRAM address/control are held per access (must be 1..15).
REQ-002 Parameter BASE_ADDR, default 1024: byte address that maps to SRAM word 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  write request from MEM stage; held until ready seen high.
REQ-006 rd_en  input  1  read request from MEM stage; held until ready seen high.
REQ-007 address  input  32  byte address from ALU result.
REQ-008 write_data  input  32  store data.
REQ-009 read_data  output  32  registered load data, valid while ready=1 after a read.
REQ-010 ready  output  1  low = pipeline must freeze; high = access finished or none pending.
REQ-011 SRAM_ADDR  output  17  SRAM word address.
REQ-012 SRAM_WE_N  output  1  SRAM write enable, active low.
REQ-013 SRAM_DQ  inout  64  SRAM data bus; SRAM returns {word[addr|1], word[addr&~1]} on read and stores the low 32 bits on write.

Function
REQ-014 States: IDLE, ACCESS, DONE; 4-bit cycle counter cnt.
REQ-015 IDLE: if wr_en or rd_en -> latch op, address, write_data; cnt<=0; go ACCESS. Else stay.
REQ-016 Both wr_en and rd_en high: write SHALL take priority; no read performed.
REQ-017 ACCESS: cnt increments each cycle; when cnt==WAIT_CYCLES-1 go DONE (exactly WAIT_CYCLES cycles in ACCESS).
REQ-018 DONE: unconditionally go IDLE next cycle.
REQ-019 ready = 1 in DONE; 0 in ACCESS; in IDLE = ~(wr_en|rd_en) (combinational).
REQ-020 Word address = (latched address - BASE_ADDR) >> 2, truncated to 17 bits (wraps modulo 2^17); address[1:0] ignored.
REQ-021 SRAM_ADDR = word address during ACCESS; 0 in IDLE and DONE.
REQ-022 SRAM_WE_N = 0 during every ACCESS cycle of a write; 1 in all other cases.
REQ-023 SRAM_DQ driven with {32'b0, latched write_data} exactly when SRAM_WE_N=0; high-impedance otherwise.
REQ-024 Read: on the last ACCESS cycle capture read_data <= word-address bit0 ? SRAM_DQ[63:32] : SRAM_DQ[31:0].
REQ-025 read_data holds its value until the next completed read; writes leave it unchanged.
REQ-026 Latency: request sampled in IDLE at cycle N -> ready high in cycle N+WAIT_CYCLES+1 (DONE) for exactly one cycle.
REQ-027 Request still asserted in the cycle after DONE is treated as a new access (requester deasserts or advances on ready).
REQ-028 Changes on address/write_data/rd_en/wr_en during ACCESS SHALL be ignored.

Reset
REQ-029 reset=1 at a rising edge: state<=IDLE, cnt<=0, read_data<=0, latched registers <=0, from any state.
REQ-030 Reset mid-ACCESS: SRAM_WE_N=1 and SRAM_DQ=Z from the following cycle; aborted read does not update read_data.
REQ-031 During reset with no request: ready=1, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ=Z.

Verification (WAIT_CYCLES=5, BASE_ADDR=1024)
REQ-032 Write address=1024, data=0xDEADBEEF -> ready low 5 cycles, SRAM_ADDR=0, SRAM_WE_N=0 for 5 cycles, ready high in 6th cycle; SRAM word 0 = 0xDEADBEEF.
REQ-033 Write 0x12345678 to 1028, then read 1028 -> read_data=0x12345678 (upper half selected); read 1024 -> 0xDEADBEEF (lower half).
REQ-034 wr_en=rd_en=1 at 1032, data=0xA5A5A5A5 -> write performed, read_data unchanged.
REQ-035 Reset asserted on 3rd ACCESS cycle of a write -> next cycle IDLE, SRAM_WE_N=1, ready=~request, read_data=0.
REQ-036 Back-to-back reads held with rd_en high through DONE -> second access starts the cycle after DONE, ready low again for 5 cycles.
REQ-037 Address 1020 (below base) -> SRAM_ADDR=0x1FFFF (wrap), access completes normally.
